// File: rtl/wb_dsz_pkg.sv
// Shared types for the 16-to-8 bit Wishbone data-size bridge.
package wb_dsz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } resp_kind_e;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Saturating stall counter; flags expiry once TIMEOUT stalled cycles have been seen.
module wb_ack_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // TIMEOUT of zero disables expiry altogether
    assign o_expired = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/wb_dsz16to8_bridge.sv
// Wishbone classic bridge: 16-bit slave port to 8-bit master port,
// one byte cycle per selected lane (low lane first), read bytes gathered into a word.
module wb_dsz16to8_bridge
    import wb_dsz_pkg::*;
#(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWIDTH-1:0] wbs_adr_i,
    input  logic [15:0]       wbs_dat_i,
    output logic [15:0]       wbs_dat_o,
    input  logic [1:0]        wbs_sel_i,
    input  logic              wbs_we_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              wbs_rty_o,
    output logic [AWIDTH-1:0] wbm_adr_o,
    output logic [7:0]        wbm_dat_o,
    input  logic [7:0]        wbm_dat_i,
    output logic              wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic              wbm_rty_i
);

    state_e            r_state, w_state_nxt;
    resp_kind_e        r_kind, w_kind_nxt;
    logic [AWIDTH-2:0] r_adr;
    logic [15:0]       r_wdat;
    logic [15:0]       r_rbuf;
    logic [15:0]       r_dat_o;
    logic              r_sel_hi;
    logic              r_we;
    logic [1:0]        r_hold;
    logic              r_ack, r_err, r_rty;

    logic w_lane, w_busy, w_pulse, w_req, w_fire;
    logic w_accept, w_cap_lo, w_cap_hi, w_lane_chg;
    logic w_expired, w_wd_clear, w_wd_en;
    logic w_unused_adr0;

    assign w_unused_adr0 = wbs_adr_i[0];

    assign w_lane  = (r_state == HI) ? LANE_HI : LANE_LO;
    // r_hold counts down the turnaround cycles before a lane's strobe is driven
    assign w_busy  = ((r_state == LO) || (r_state == HI)) && (r_hold == '0);
    assign w_pulse = r_ack | r_err | r_rty;
    assign w_req   = wbs_cyc_i & wbs_stb_i & ~w_pulse;
    assign w_fire  = (r_state == RESP) & wbs_cyc_i;

    assign wbm_cyc_o = w_busy & wbs_cyc_i;
    assign wbm_stb_o = wbm_cyc_o & wbs_stb_i;
    assign wbm_sel_o = wbm_cyc_o;
    assign wbm_adr_o = {r_adr, w_lane};
    assign wbm_dat_o = (w_lane == LANE_HI) ? r_wdat[15:8] : r_wdat[7:0];
    assign wbm_we_o  = r_we;

    assign wbs_dat_o = r_dat_o;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign wbs_rty_o = r_rty;

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_accept    = 1'b0;
        w_cap_lo    = 1'b0;
        w_cap_hi    = 1'b0;
        w_lane_chg  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept   = 1'b1;
                    w_kind_nxt = RSP_ACK;
                    if (wbs_sel_i[0])      w_state_nxt = LO;
                    else if (wbs_sel_i[1]) w_state_nxt = HI;
                    else                   w_state_nxt = RESP;
                end
            end
            LO, HI: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (wbm_stb_o && wbm_err_i) begin
                    w_state_nxt = RESP;
                    w_kind_nxt  = RSP_ERR;
                end else if (wbm_stb_o && wbm_rty_i) begin
                    w_state_nxt = RESP;
                    w_kind_nxt  = RSP_RTY;
                end else if (wbm_stb_o && wbm_ack_i) begin
                    w_kind_nxt = RSP_ACK;
                    if (r_state == LO) begin
                        w_cap_lo = 1'b1;
                        if (r_sel_hi) begin
                            w_state_nxt = HI;
                            w_lane_chg  = 1'b1;
                        end else begin
                            w_state_nxt = RESP;
                        end
                    end else begin
                        w_cap_hi    = 1'b1;
                        w_state_nxt = RESP;
                    end
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                    w_kind_nxt  = RSP_ERR;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_kind  <= RSP_ACK;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_adr    <= '0;
            r_wdat   <= '0;
            r_rbuf   <= '0;
            r_sel_hi <= 1'b0;
            r_we     <= 1'b0;
            r_hold   <= '0;
        end else if (w_accept) begin
            r_adr    <= wbs_adr_i[AWIDTH-1:1];
            r_wdat   <= wbs_dat_i;
            r_rbuf   <= '0;
            r_sel_hi <= wbs_sel_i[1];
            r_we     <= wbs_we_i;
            r_hold   <= 2'd1;
        end else begin
            // a lane change waits two cycles so the byte slave sees a clean gap
            if (w_lane_chg)          r_hold <= 2'd2;
            else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
            if (w_cap_lo && !r_we)   r_rbuf[7:0]  <= wbm_dat_i;
            if (w_cap_hi && !r_we)   r_rbuf[15:8] <= wbm_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_fire && (r_kind == RSP_ACK);
            r_err   <= w_fire && (r_kind == RSP_ERR);
            r_rty   <= w_fire && (r_kind == RSP_RTY);
            r_dat_o <= w_fire ? r_rbuf : '0;
        end
    end

    assign w_wd_clear = (w_state_nxt != r_state) | ~w_busy;
    assign w_wd_en    = wbm_stb_o & ~(wbm_ack_i | wbm_err_i | wbm_rty_i);

    wb_ack_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_en),
        .o_expired(w_expired)
    );

endmodule

// File: tb/tb_wb_dsz16to8_bridge.sv
// Scoreboard bench for the 16-to-8 bridge against an 8-bit slave model with ACK_DELAY=2.
module tb_wb_dsz16to8_bridge;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 4;
    localparam int unsigned D   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wbs_adr = '0;
    logic [15:0]   wbs_dat_w = '0;
    logic [15:0]   wbs_dat_r;
    logic [1:0]    wbs_sel = '0;
    logic          wbs_we = 1'b0, wbs_cyc = 1'b0, wbs_stb = 1'b0;
    logic          wbs_ack, wbs_err, wbs_rty;
    logic [AW-1:0] wbm_adr;
    logic [7:0]    wbm_dat_w, wbm_dat_r;
    logic          wbm_sel, wbm_we, wbm_cyc, wbm_stb;
    logic          wbm_ack, wbm_err, wbm_rty;

    wb_dsz16to8_bridge #(
        .AWIDTH (AW),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .wbs_adr_i(wbs_adr),
        .wbs_dat_i(wbs_dat_w),
        .wbs_dat_o(wbs_dat_r),
        .wbs_sel_i(wbs_sel),
        .wbs_we_i (wbs_we),
        .wbs_cyc_i(wbs_cyc),
        .wbs_stb_i(wbs_stb),
        .wbs_ack_o(wbs_ack),
        .wbs_err_o(wbs_err),
        .wbs_rty_o(wbs_rty),
        .wbm_adr_o(wbm_adr),
        .wbm_dat_o(wbm_dat_w),
        .wbm_dat_i(wbm_dat_r),
        .wbm_sel_o(wbm_sel),
        .wbm_we_o (wbm_we),
        .wbm_cyc_o(wbm_cyc),
        .wbm_stb_o(wbm_stb),
        .wbm_ack_i(wbm_ack),
        .wbm_err_i(wbm_err),
        .wbm_rty_i(wbm_rty)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- 8-bit slave model ----------------
    logic [7:0]  ram [256];
    int unsigned s_cnt = 0;
    logic        s_hang = 1'b0, s_err_lo = 1'b0, s_rty = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_adr = '0, pl_dat = '0;
    logic        s_hit, s_err_now;

    assign s_hit     = wbm_cyc & wbm_stb & (s_cnt == D - 1) & ~s_hang;
    assign s_err_now = s_err_lo & ~wbm_adr[0];
    assign wbm_err   = s_hit & s_err_now;
    assign wbm_rty   = s_hit & s_rty & ~s_err_now;
    assign wbm_ack   = s_hit & ~s_rty & ~s_err_now;
    assign wbm_dat_r = ram[wbm_adr];

    always @(posedge clk) begin
        if (wbm_cyc && wbm_stb && !s_hit) s_cnt <= s_cnt + 1;
        else                              s_cnt <= 0;
        if (pl_en)                        ram[pl_adr] <= pl_dat;
        else if (wbm_ack && wbm_we)       ram[wbm_adr] <= wbm_dat_w;
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_adr = a; pl_dat = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [7:0] adr;
        logic       we;
        logic [7:0] dat;
    } dn_t;

    typedef struct {
        int          kind;    // 0 ack, 1 err, 2 rty
        logic [15:0] dat;
        int unsigned lat;
        int unsigned t0;
    } up_t;

    dn_t dn_q[$];
    up_t up_q[$];

    task automatic exp_dn(input logic [7:0] a, input logic we, input logic [7:0] d);
        dn_t e;
        e.adr = a; e.we = we; e.dat = d;
        dn_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wbm_cyc && wbm_stb && (wbm_ack || wbm_err || wbm_rty)) begin
            if (dn_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL dn_unexpected: got access at 0x%0h want none", wbm_adr);
            end else begin
                dn_t e;
                e = dn_q.pop_front();
                chk("dn_adr", 32'(wbm_adr), 32'(e.adr));
                chk("dn_we", 32'(wbm_we), 32'(e.we));
                chk("dn_sel", 32'(wbm_sel), 32'd1);
                if (e.we) chk("dn_wdat", 32'(wbm_dat_w), 32'(e.dat));
            end
        end
    end

    always @(negedge clk) begin
        if (wbs_ack || wbs_err || wbs_rty) begin
            chk("up_onehot", 32'(int'(wbs_ack) + int'(wbs_err) + int'(wbs_rty)), 32'd1);
            if (up_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL up_unexpected: got pulse ack=%0b err=%0b rty=%0b want none",
                         wbs_ack, wbs_err, wbs_rty);
            end else begin
                up_t e;
                int  k;
                e = up_q.pop_front();
                k = wbs_err ? 1 : (wbs_rty ? 2 : 0);
                chk("up_kind", 32'(k), 32'(e.kind));
                chk("up_dat", 32'(wbs_dat_r), 32'(e.dat));
                chk("up_lat", cyc_cnt - e.t0, e.lat);
            end
        end
    end

    task automatic req(input logic [7:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                       input logic we, input int kind, input logic [15:0] edat,
                       input int unsigned elat);
        up_t e;
        int unsigned k;
        @(posedge clk); #1;
        e.kind = kind; e.dat = edat; e.lat = elat; e.t0 = cyc_cnt;
        up_q.push_back(e);
        wbs_adr = adr; wbs_dat_w = dat; wbs_sel = sel; wbs_we = we;
        wbs_cyc = 1'b1; wbs_stb = 1'b1;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (wbs_ack || wbs_err || wbs_rty) break;
        end
        if (k == 64) begin
            n_checks++; n_err++;
            $display("FAIL req_timeout: got no response at adr 0x%0h want one within 64 cycles", adr);
            void'(up_q.pop_back());
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int unsigned k;
        logic        seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_up", {wbs_dat_r, 13'b0, wbs_ack, wbs_err, wbs_rty}, 32'h0);
        chk("rst_dn", {14'b0, wbm_adr, wbm_dat_w, wbm_cyc, wbm_stb}, 32'h0);
        chk("rst_we", 32'(wbm_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        preload(8'h21, 8'h3C);
        preload(8'h30, 8'h77);
        preload(8'hFE, 8'h11);
        preload(8'hFF, 8'h22);
        preload(8'h40, 8'h99);

        // two-lane write
        exp_dn(8'h10, 1'b1, 8'h5A);
        exp_dn(8'h11, 1'b1, 8'hA5);
        req(8'h10, 16'hA55A, 2'b11, 1'b1, 0, 16'h0000, 9);
        chk("ram_10", 32'(ram[8'h10]), 32'h5A);
        chk("ram_11", 32'(ram[8'h11]), 32'hA5);

        // high lane only read
        exp_dn(8'h21, 1'b0, 8'h00);
        req(8'h20, 16'h0000, 2'b10, 1'b0, 0, 16'h3C00, 5);

        // no lanes selected
        req(8'h30, 16'hBEEF, 2'b00, 1'b1, 0, 16'h0000, 2);
        chk("ram_30", 32'(ram[8'h30]), 32'h77);

        // read back the two-lane write
        exp_dn(8'h10, 1'b0, 8'h00);
        exp_dn(8'h11, 1'b0, 8'h00);
        req(8'h10, 16'h0000, 2'b11, 1'b0, 0, 16'hA55A, 9);

        // top of address space, no carry
        exp_dn(8'hFE, 1'b0, 8'h00);
        exp_dn(8'hFF, 1'b0, 8'h00);
        req(8'hFF, 16'h0000, 2'b11, 1'b0, 0, 16'h2211, 9);

        // slave error on lane 0, lane 1 skipped
        s_err_lo = 1'b1;
        exp_dn(8'h50, 1'b0, 8'h00);
        req(8'h50, 16'h0000, 2'b11, 1'b0, 1, 16'h0000, 5);
        s_err_lo = 1'b0;

        // slave retry, write not committed
        s_rty = 1'b1;
        exp_dn(8'h60, 1'b1, 8'h34);
        req(8'h60, 16'h1234, 2'b01, 1'b1, 2, 16'h0000, 5);
        s_rty = 1'b0;
        chk("ram_60", 32'(ram[8'h60]) & 32'hFF, 32'(ram[8'h60] === 8'h34 ? 8'h00 : ram[8'h60]) & 32'hFF);

        // hung slave: watchdog fires after TMO stalled strobe cycles
        s_hang = 1'b1;
        req(8'h70, 16'h0000, 2'b01, 1'b0, 1, 16'h0000, TMO + 4);
        s_hang = 1'b0;
        @(negedge clk);
        chk("wd_idle_cyc", 32'(wbm_cyc), 32'd0);
        exp_dn(8'h21, 1'b0, 8'h00);
        req(8'h20, 16'h0000, 2'b10, 1'b0, 0, 16'h3C00, 5);

        // abort during lane 1
        exp_dn(8'h40, 1'b0, 8'h00);
        @(posedge clk); #1;
        wbs_adr = 8'h40; wbs_sel = 2'b11; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        for (k = 0; k < 32; k++) begin
            @(negedge clk);
            if (wbm_stb && wbm_adr[0]) break;
        end
        chk("abort_reached_hi", 32'(k < 32), 32'd1);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        #1;
        chk("abort_cyc", 32'(wbm_cyc), 32'd0);
        chk("abort_stb", 32'(wbm_stb), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | wbs_ack | wbs_err | wbs_rty | wbm_cyc;
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        // asynchronous reset mid-transfer
        @(posedge clk); #1;
        wbs_adr = 8'h42; wbs_sel = 2'b01; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        for (k = 0; k < 32; k++) begin
            @(negedge clk);
            if (wbm_stb) break;
        end
        chk("rst_reached_lo", 32'(k < 32), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_up", {wbs_dat_r, 13'b0, wbs_ack, wbs_err, wbs_rty}, 32'h0);
        chk("midrst_dn", {14'b0, wbm_adr, wbm_dat_w, wbm_cyc, wbm_stb}, 32'h0);
        @(negedge clk);
        chk("midrst_hold", {13'b0, wbs_ack, wbs_err, wbs_rty, wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_w}, 32'h0);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        exp_dn(8'h21, 1'b0, 8'h00);
        req(8'h20, 16'h0000, 2'b10, 1'b0, 0, 16'h3C00, 5);

        repeat (3) @(negedge clk);
        chk("up_q_empty", 32'(up_q.size()), 32'd0);
        chk("dn_q_empty", 32'(dn_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
